// File: rtl/fetch_sequencer_pkg.sv
// Shared types and default widths for the K2 fetch sequencer slice.
// Holds the sequencer state encoding and a program-bounds helper.
package fetch_sequencer_pkg;

  localparam int ADDR_W_DEF   = 4;
  localparam int DATA_W_DEF   = 8;
  localparam int PROG_LEN_DEF = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  // True when an address lies inside the loaded program image.
  function automatic logic addr_in_prog(input int unsigned addr, input int unsigned prog_len);
    return (addr < prog_len);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer, the instruction ROM and the decode stage.
// master = sequencer side, slave = surrounding core/ROM/decode side.
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              start;
  logic              halt_req;
  logic              jump_valid;
  logic [ADDR_W-1:0] jump_addr;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              halted;
  logic              fault;

  modport master (
    input  start, halt_req, jump_valid, jump_addr, rom_data, instr_ready,
    output rom_addr, instr, instr_pc, instr_valid, halted, fault
  );

  modport slave (
    output start, halt_req, jump_valid, jump_addr, rom_data, instr_ready,
    input  rom_addr, instr, instr_pc, instr_valid, halted, fault
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the K2 instruction ROM: presents pc, registers the
// fetched byte, and hands it to decode over valid/ready with jump, halt and fault.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int PROG_LEN = PROG_LEN_DEF,
  parameter bit WRAP     = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_sequencer_if.master  fs
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc_p0, pc_nxt;
  logic [DATA_W-1:0] instr_p1, instr_nxt;
  logic [ADDR_W-1:0] instr_pc_p1, instr_pc_nxt;
  logic              vld_p1, vld_nxt;
  logic              fault_q, fault_nxt;

  logic accept;
  logic slot_free;
  logic jump_ok;

  assign accept    = vld_p1 && fs.instr_ready;
  assign slot_free = !vld_p1 || fs.instr_ready;
  assign jump_ok   = addr_in_prog(int'(fs.jump_addr), PROG_LEN);

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_p0;
    instr_nxt    = instr_p1;
    instr_pc_nxt = instr_pc_p1;
    vld_nxt      = vld_p1;
    fault_nxt    = fault_q;

    case (state)
      IDLE, HALTED: begin
        if (fs.start) begin
          state_nxt = FETCH;
          pc_nxt    = '0;
          fault_nxt = 1'b0;
          vld_nxt   = 1'b0;
        end
      end

      FETCH: begin
        if (fs.jump_valid) begin
          // Redirect flushes the held instruction; the target is fetched next cycle.
          vld_nxt = 1'b0;
          if (jump_ok) begin
            pc_nxt = fs.jump_addr;
          end else begin
            fault_nxt = 1'b1;
            state_nxt = HALTED;
          end
        end else if (fs.halt_req) begin
          if (slot_free) begin
            vld_nxt   = 1'b0;
            state_nxt = HALTED;
          end else begin
            state_nxt = DRAIN;
          end
        end else if (slot_free) begin
          instr_nxt    = fs.rom_data;
          instr_pc_nxt = pc_p0;
          vld_nxt      = 1'b1;
          if (pc_p0 != LAST_PC) begin
            pc_nxt = pc_p0 + ADDR_W'(1);
          end else if (WRAP) begin
            pc_nxt = '0;
          end else begin
            // Last entry still goes out through DRAIN; pc stays inside the program.
            fault_nxt = 1'b1;
            state_nxt = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (fs.jump_valid) begin
          vld_nxt   = 1'b0;
          state_nxt = HALTED;
          if (!jump_ok) fault_nxt = 1'b1;
        end else if (!vld_p1 || accept) begin
          vld_nxt   = 1'b0;
          state_nxt = HALTED;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Stage boundary: pc presented to ROM (p0) -> instruction register (p1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc_p0       <= '0;
      instr_p1    <= '0;
      instr_pc_p1 <= '0;
      vld_p1      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc_p0       <= pc_nxt;
      instr_p1    <= instr_nxt;
      instr_pc_p1 <= instr_pc_nxt;
      vld_p1      <= vld_nxt;
      fault_q     <= fault_nxt;
    end
  end

  assign fs.rom_addr    = pc_p0;
  assign fs.instr       = instr_p1;
  assign fs.instr_pc    = instr_pc_p1;
  assign fs.instr_valid = vld_p1;
  assign fs.halted      = (state == HALTED);
  assign fs.fault       = fault_q;

endmodule
